// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALU ops,
// immediate formats, opcodes and datapath mux selects.
package multicycle_control_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR      = 4'd11;
  localparam logic [3:0] S_FAULT     = 4'd12;
  localparam logic [3:0] S_LUI       = 4'd13;
  localparam logic [3:0] S_AUIPC     = 4'd14;

  typedef enum logic [1:0] {
    ALU_OP_ADD  = 2'b00,
    ALU_OP_SUB  = 2'b01,
    ALU_OP_FUNC = 2'b10
  } alu_op_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_REG   = 2'b00;
  localparam logic [1:0] RES_READ_DATA = 2'b01;
  localparam logic [1:0] RES_ALU       = 2'b10;

  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU control decode from alu_op, func3, func7[5] and op_code[5].
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_func3,
  input  logic       i_func7_5,
  input  logic       i_op_code_5,
  output logic [3:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALU_OP_ADD: o_alu_control = ALU_ADD;
      ALU_OP_SUB: o_alu_control = ALU_SUB;
      ALU_OP_FUNC: begin
        case (i_func3)
          // op_code[5] separates R-type from I-type, where bit 30 is immediate data
          3'b000:  o_alu_control = (i_op_code_5 && i_func7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_SLTU;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = i_func7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM with memory-ready handshake and timeout.
// Build option: define CTRL_UTYPE_EN to decode LUI/AUIPC instead of faulting on them.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_CTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op_code,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_type,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_instr,
  output logic                  bus_error,
  output logic [3:0]            dbg_state
);

  logic [3:0] r_state;
  logic [7:0] r_wait;
  logic       r_illegal;
  logic       r_bus_error;

  logic [3:0] w_next;
  logic       w_set_illegal;
  logic       w_timeout;
  logic       w_is_mem;
  logic       w_taken;
  alu_op_t    w_alu_op;
  logic [3:0] w_alu_ctrl;
  logic       w_unused_func7;

  assign w_unused_func7 = ^{func7[6], func7[4:0]};
  assign w_is_mem  = is_mem_state(r_state);
  // A ready arriving on the last allowed wait cycle still completes normally
  assign w_timeout = w_is_mem && !mem_ready && (r_wait == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    case (func3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = !zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = !lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = !ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RES_ALU_REG;
    imm_type      = IMM_I;
    w_alu_op      = ALU_OP_ADD;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_type  = IMM_B;
        case (op_code)
          OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
`ifdef CTRL_UTYPE_EN
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
`endif
          default: begin
            w_next        = S_FAULT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_type  = op_code[5] ? IMM_S : IMM_I;
        w_next    = op_code[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)      w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_READ_DATA;
        w_next     = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        w_alu_op  = ALU_OP_FUNC;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        w_alu_op  = ALU_OP_FUNC;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        w_alu_op  = ALU_OP_SUB;
        if (func3 == 3'b010 || func3 == 3'b011) begin
          w_next        = S_FAULT;
          w_set_illegal = 1'b1;
        end else begin
          pc_write = w_taken;
          w_next   = S_FETCH;
        end
      end
      S_JAL: begin
        // PC takes the target latched during DECODE; ALU forms the link value
        pc_write  = 1'b1;
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        w_next    = S_ALU_WB;
      end
      S_JALR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        w_next     = S_ALU_WB;
      end
`ifdef CTRL_UTYPE_EN
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        imm_type  = IMM_U;
        w_next    = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_type  = IMM_U;
        w_next    = S_ALU_WB;
      end
`endif
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      result_src = RES_ALU_REG;
      imm_type   = IMM_I;
      w_alu_op   = ALU_OP_ADD;
    end
  end

  multicycle_control_alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_func3       (func3),
    .i_func7_5     (func7[5]),
    .i_op_code_5   (op_code[5]),
    .o_alu_control (w_alu_ctrl)
  );

  assign alu_control   = ALU_CTRL_W'(w_alu_ctrl);
  assign illegal_instr = r_illegal && !reset;
  assign bus_error     = r_bus_error && !reset;
  assign dbg_state     = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_wait      <= 8'd0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal   <= 1'b1;
      if (w_timeout)     r_bus_error <= 1'b1;
      // Memory states are left only on ready or timeout, so clearing here also clears on entry
      if (w_is_mem && !mem_ready && !w_timeout) r_wait <= r_wait + 8'd1;
      else                                      r_wait <= 8'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle model, one compare process, literal checks.
// Build option CTRL_UTYPE_EN switches the LUI/AUIPC expectations.
module tb_multicycle_control;

  localparam int MEM_TIMEOUT = 16;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op_code = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_type;
  logic [3:0] alu_control;
  logic       illegal_instr, bus_error;
  logic [3:0] dbg_state;

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .ALU_CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .func3(func3), .func7(func7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_type(imm_type), .alu_control(alu_control),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [21:0] exp_q[$];
  bit m_ill = 0, m_bus = 0, m_fault = 0;
  int ncyc, cnt_rw, cnt_pcw, cnt_mreq, cnt_mwr, cnt_sub;
  logic [6:0] ir_op = '0;
  logic [2:0] ir_f3 = '0;
  logic [6:0] ir_f7 = '0;
  bit fz = 0, fl = 0, flu = 0;

  wire [21:0] act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, result_src, imm_type, alu_control,
                     illegal_instr, bus_error};

  // Single compare process: one expected vector per cycle
  initial begin
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (act !== e) begin
          n_err++;
          $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, e);
        end
      end
    end
  end

  function automatic logic [21:0] mk(input bit mreq, mwr, adr, irw, pcw, rw,
                                     input logic [1:0] a, b, rs, input logic [2:0] imm,
                                     input logic [3:0] alu);
    return {mreq, mwr, adr, irw, pcw, rw, a, b, rs, imm, alu, m_ill, m_bus};
  endfunction

  // ALU function from the instruction fields, stated as the ISA rules
  function automatic logic [3:0] alu_ref(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (f3 == 3'd0 && op == OP_R && f7[5]) return 4'd1;
    if (f3 == 3'd5 && f7[5]) return 4'd9;
    return tbl[f3];
  endfunction

  task automatic lit(input string nm, input int a, input int r);
    n_cmp++;
    if (a !== r) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, a, r);
    end
  endtask

  task automatic cyc(input bit rst, input bit rdy, input logic [21:0] e);
    @(posedge clk);
    #1;
    reset = rst; mem_ready = rdy;
    op_code = ir_op; func3 = ir_f3; func7 = ir_f7;
    zero = fz; lt = fl; ltu = flu;
    exp_q.push_back(e);
    ncyc++;
    @(negedge clk);
    #1;
    cnt_rw += int'(reg_write); cnt_pcw += int'(pc_write);
    cnt_mreq += int'(mem_req); cnt_mwr += int'(mem_write);
    cnt_sub += int'(alu_control == 4'd1);
  endtask

  task automatic clr_cnt();
    ncyc = 0; cnt_rw = 0; cnt_pcw = 0; cnt_mreq = 0; cnt_mwr = 0; cnt_sub = 0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 22'h0);
    m_ill = 0; m_bus = 0; m_fault = 0;
  endtask

  // kind 0 = instruction fetch, 1 = load, 2 = store; waits = cycles before ready
  task automatic mem_phase(input int kind, input int waits);
    bit rdy;
    logic [21:0] e;
    for (int i = 0; i <= waits; i++) begin
      rdy = (i == waits);
      if (kind == 0)      e = mk(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b10, 3'b000, 4'd0);
      else if (kind == 1) e = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
      else                e = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
      cyc(1'b0, rdy, e);
      if (!rdy && i + 1 == MEM_TIMEOUT) begin
        m_bus = 1; m_fault = 1;
        break;
      end
    end
  endtask

  task automatic wb_alu();
    cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0));
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input bit z, l, lu, input int fw, input int mw);
    bit taken, bad;
    ir_op = op; ir_f3 = f3; ir_f7 = f7; fz = z; fl = l; flu = lu;
    mem_phase(0, fw);
    if (m_fault) return;
    cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, 4'd0));
    case (op)
      OP_LOAD: begin
        cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 4'd0));
        mem_phase(1, mw);
        if (!m_fault)
          cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 4'd0));
      end
      OP_STORE: begin
        cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, 4'd0));
        mem_phase(2, mw);
      end
      OP_R: begin
        cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, alu_ref(op, f3, f7)));
        wb_alu();
      end
      OP_I: begin
        cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, alu_ref(op, f3, f7)));
        wb_alu();
      end
      OP_BRANCH: begin
        bad = (f3 == 3'd2 || f3 == 3'd3);
        case (f3)
          3'd0: taken = z;
          3'd1: taken = !z;
          3'd4: taken = l;
          3'd5: taken = !l;
          3'd6: taken = lu;
          3'd7: taken = !lu;
          default: taken = 0;
        endcase
        cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, taken && !bad, 0, 2'b10, 2'b00, 2'b00, 3'b000, 4'd1));
        if (bad) begin m_ill = 1; m_fault = 1; end
      end
      OP_JAL: begin
        cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b000, 4'd0));
        wb_alu();
      end
      OP_JALR: begin
        cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 3'b000, 4'd0));
        wb_alu();
      end
`ifdef CTRL_UTYPE_EN
      OP_LUI: begin
        cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 3'b100, 4'd0));
        wb_alu();
      end
      OP_AUIPC: begin
        cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b100, 4'd0));
        wb_alu();
      end
`endif
      default: begin m_ill = 1; m_fault = 1; end
    endcase
  endtask

  task automatic fault_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0));
  endtask

  task automatic recover_if_fault();
    if (m_fault) begin
      fault_cycles(3);
      do_reset(2);
    end
  endtask

  initial begin
    logic [6:0] ops [9];
    logic [6:0] op;
    logic [6:0] f7;
    int fw, mw;
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    clr_cnt();
    do_reset(2);
    lit("reset_mem_req", cnt_mreq, 0);

    clr_cnt(); run_instr(OP_R, 3'd0, 7'b0000000, 0, 0, 0, 0, 0);
    lit("add_cycles", ncyc, 4); lit("add_reg_write", cnt_rw, 1); lit("add_no_sub", cnt_sub, 0);
    clr_cnt(); run_instr(OP_R, 3'd0, 7'b0100000, 0, 0, 0, 0, 0);
    lit("sub_alu_ctrl", cnt_sub, 1);
    clr_cnt(); run_instr(OP_LOAD, 3'd2, 7'd0, 0, 0, 0, 0, 3);
    lit("lw_cycles", ncyc, 8); lit("lw_mem_req", cnt_mreq, 5); lit("lw_reg_write", cnt_rw, 1);
    clr_cnt(); run_instr(OP_BRANCH, 3'd0, 7'd0, 1, 0, 0, 0, 0);
    lit("beq_cycles", ncyc, 3); lit("beq_pc_write", cnt_pcw, 2);
    clr_cnt(); run_instr(OP_BRANCH, 3'd6, 7'd0, 0, 1, 0, 0, 0);
    lit("bltu_pc_write", cnt_pcw, 1);
    clr_cnt(); run_instr(OP_STORE, 3'd2, 7'd0, 0, 0, 0, 0, 0);
    lit("sw_cycles", ncyc, 4); lit("sw_mem_write", cnt_mwr, 1);
    clr_cnt(); run_instr(OP_JAL, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    lit("jal_cycles", ncyc, 4);
    clr_cnt(); run_instr(OP_JALR, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    lit("jalr_cycles", ncyc, 4);

    clr_cnt(); run_instr(OP_LUI, 3'd0, 7'd0, 0, 0, 0, 0, 0);
`ifdef CTRL_UTYPE_EN
    lit("lui_cycles", ncyc, 4); lit("lui_reg_write", cnt_rw, 1);
`else
    fault_cycles(1);
    lit("lui_illegal", int'(illegal_instr), 1);
    lit("lui_no_reg_write", cnt_rw, 0);
`endif
    recover_if_fault();

    // Fetch that never sees ready
    clr_cnt(); run_instr(OP_R, 3'd0, 7'd0, 0, 0, 0, 100, 0);
    lit("timeout_wait_cycles", ncyc, MEM_TIMEOUT);
    clr_cnt(); fault_cycles(4);
    lit("timeout_bus_error", int'(bus_error), 1);
    lit("fault_no_mem_req", cnt_mreq, 0);
    recover_if_fault();
    lit("post_reset_bus_error", int'(bus_error), 0);

    // Reset while a store waits for ready
    ir_op = OP_STORE; ir_f3 = 3'd2; ir_f7 = 7'd0;
    mem_phase(0, 0);
    cyc(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, 4'd0));
    cyc(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, 4'd0));
    cyc(1'b0, 1'b0, mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0));
    cyc(1'b0, 1'b0, mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0));
    clr_cnt(); do_reset(1);
    run_instr(OP_I, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    lit("reset_mid_write_no_store", cnt_mwr, 0);
    lit("reset_mid_write_cycles", ncyc, 5);

    for (int n = 0; n < 250; n++) begin
      op = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 2))
        0: f7 = 7'b0000000;
        1: f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      fw = ($urandom_range(0, 29) == 0) ? 20 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 14) == 0) ? MEM_TIMEOUT + $urandom_range(0, 4) : $urandom_range(0, 4);
      run_instr(op, 3'($urandom), f7, 1'($urandom), 1'($urandom), 1'($urandom), fw, mw);
      recover_if_fault();
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    lit("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
